// File: rtl/prescaled_timer_if.sv
// Control/status bundle between register logic and the prescaled timer.
// The master side programs the timer; the slave side is the timer itself.
interface prescaled_timer_if #(
  parameter int WIDTH = 16,
  parameter int PSC_W = 5
);
  logic             en;
  logic             load;
  logic [1:0]       mode;
  logic             one_shot;
  logic [PSC_W-1:0] psc;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] cmp;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             done;
  logic             dir;
  logic             running;
  logic             cmp_match;
  logic             pwm;

  modport master (
    output en, load, mode, one_shot, psc, reload, cmp,
    input  count, tick, done, dir, running, cmp_match, pwm
  );
  modport slave (
    input  en, load, mode, one_shot, psc, reload, cmp,
    output count, tick, done, dir, running, cmp_match, pwm
  );
endinterface

// File: rtl/prescaled_timer.sv
// Prescaled timer/counter: down, up and centre-aligned up-down counting with
// auto-reload or one-shot stop, plus compare match and PWM outputs.
module prescaled_timer #(
  parameter int WIDTH = 16,
  parameter int PSC_W = 5
) (
  input logic               clk,
  input logic               reset,
  prescaled_timer_if.slave  tif
);

  logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             dir_q, dir_d;
  logic             running_q, running_d;

  logic act, step, is_down;

  assign act     = tif.en & running_q;
  // >= rather than == so lowering psc mid-run cannot strand the prescaler
  assign step    = act & (psc_cnt_q >= tif.psc);
  assign is_down = (tif.mode == 2'b00) || (tif.mode == 2'b11);

  always_comb begin
    psc_cnt_d = psc_cnt_q;
    count_d   = count_q;
    dir_d     = dir_q;
    running_d = running_q;
    tick_d    = step;
    done_d    = 1'b0;
    if (tif.load) begin
      psc_cnt_d = '0;
      running_d = 1'b1;
      tick_d    = 1'b0;
      count_d   = is_down ? tif.reload : '0;
      dir_d     = is_down;
    end else if (step) begin
      psc_cnt_d = '0;
      if (is_down) begin
        if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end else begin
          done_d = 1'b1;
          if (tif.one_shot) running_d = 1'b0;
          else              count_d   = tif.reload;
        end
      end else if (tif.mode == 2'b01) begin
        if (count_q < tif.reload) begin
          count_d = count_q + 1'b1;
        end else begin
          done_d  = 1'b1;
          count_d = '0;
          if (tif.one_shot) running_d = 1'b0;
        end
      end else begin
        // Up-down; a zero terminal pins the count and never turns around
        if (tif.reload == '0) begin
          done_d  = 1'b1;
          count_d = '0;
          dir_d   = 1'b0;
          if (tif.one_shot) running_d = 1'b0;
        end else if (!dir_q) begin
          if (count_q < tif.reload) begin
            count_d = count_q + 1'b1;
          end else begin
            dir_d   = 1'b1;
            count_d = count_q - 1'b1;
          end
        end else if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end else begin
          done_d = 1'b1;
          dir_d  = 1'b0;
          if (tif.one_shot) running_d = 1'b0;
          else              count_d   = WIDTH'(1);
        end
      end
    end else if (act) begin
      psc_cnt_d = psc_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc_cnt_q <= '0;
      count_q   <= '0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      dir_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      psc_cnt_q <= psc_cnt_d;
      count_q   <= count_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
      dir_q     <= dir_d;
      running_q <= running_d;
    end
  end

  assign tif.count     = count_q;
  assign tif.tick      = tick_q;
  assign tif.done      = done_q;
  assign tif.dir       = dir_q;
  assign tif.running   = running_q;
  assign tif.cmp_match = (count_q == tif.cmp);
  assign tif.pwm       = (count_q < tif.cmp);

endmodule
